// File: rtl/fsm_bin2therm_dwa.sv
// Binary-to-thermometer element selector for the unary DAC, with optional
// data-weighted-averaging rotation and a settle hold-off after each accepted code.
module fsm_bin2therm_dwa #(
   parameter int unsigned Width        = 3,
   parameter int unsigned SettleCycles = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    valid_i,
   input  logic [Width-1:0]        code_i,
   input  logic                    dwa_en_i,
   output logic                    ready_o,
   output logic [(2**Width)-2:0]   therm_o,
   output logic                    valid_o,
   output logic [Width-1:0]        ptr_o
);

   localparam int unsigned Elements  = (2 ** Width) - 1;
   localparam int unsigned SumW      = Width + 1;
   localparam int unsigned CntW      = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam bit          HasSettle = (SettleCycles != 0);
   localparam logic [CntW-1:0] CntLoad = CntW'((SettleCycles > 0) ? (SettleCycles - 1) : 0);

   typedef enum logic {
      IDLE,
      SETTLE
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [Elements-1:0]  therm_q, therm_d;
   logic                 vld_q, vld_d;
   logic [Width-1:0]     ptr_q, ptr_d;
   logic                 accept;

   // Fixed LSB-first selection of the lowest `code` elements.
   function automatic logic [Elements-1:0] lsb_mask(input logic [Width-1:0] code);
      return Elements'((32'd1 << code) - 32'd1);
   endfunction

   // Circular rotate-left by ptr: bits shifted past the top wrap back to element 0.
   function automatic logic [Elements-1:0] rotate(input logic [Elements-1:0] mask,
                                                  input logic [Width-1:0]    ptr);
      logic [2*Elements-1:0] w;
      w = {{Elements{1'b0}}, mask} << ptr;
      return w[Elements-1:0] | w[2*Elements-1:Elements];
   endfunction

   // ptr + code never exceeds 2*Elements-1, so one conditional subtract suffices.
   function automatic logic [Width-1:0] ptr_wrap(input logic [Width-1:0] ptr,
                                                 input logic [Width-1:0] code);
      logic [SumW-1:0] s;
      s = {1'b0, ptr} + {1'b0, code};
      if (s >= SumW'(Elements)) begin
         s = s - SumW'(Elements);
      end
      return Width'(s);
   endfunction

   assign ready_o = (state_q == IDLE);
   assign accept  = valid_i & ready_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      therm_d = therm_q;
      vld_d   = 1'b0;
      ptr_d   = ptr_q;

      case (state_q)
         IDLE: begin
            if (accept && HasSettle) begin
               state_d = SETTLE;
               cnt_d   = CntLoad;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         vld_d = 1'b1;
         if (dwa_en_i) begin
            therm_d = rotate(lsb_mask(code_i), ptr_q);
            ptr_d   = ptr_wrap(ptr_q, code_i);
         end else begin
            therm_d = lsb_mask(code_i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         therm_q <= '0;
         vld_q   <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         therm_q <= therm_d;
         vld_q   <= vld_d;
         ptr_q   <= ptr_d;
      end
   end

   assign therm_o = therm_q;
   assign valid_o = vld_q;
   assign ptr_o   = ptr_q;

endmodule

// File: tb/tb_fsm_bin2therm_dwa.sv
// Bench for fsm_bin2therm_dwa: one instance with a 2-cycle settle, one with none,
// both checked every cycle against an element-level model plus literal expectations.
module tb_fsm_bin2therm_dwa;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       v   [2];
   logic [2:0] c   [2];
   logic       d   [2];
   logic       rdy [2];
   logic [6:0] th  [2];
   logic       vo  [2];
   logic [2:0] p   [2];

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   fsm_bin2therm_dwa #(.Width(3), .SettleCycles(2)) u_a (
      .clk_i(clk), .rst_i(rst), .valid_i(v[0]), .code_i(c[0]), .dwa_en_i(d[0]),
      .ready_o(rdy[0]), .therm_o(th[0]), .valid_o(vo[0]), .ptr_o(p[0])
   );

   fsm_bin2therm_dwa #(.Width(3), .SettleCycles(0)) u_b (
      .clk_i(clk), .rst_i(rst), .valid_i(v[1]), .code_i(c[1]), .dwa_en_i(d[1]),
      .ready_o(rdy[1]), .therm_o(th[1]), .valid_o(vo[1]), .ptr_o(p[1])
   );

   // Model: elements listed one by one; pointer advanced with plain modulo.
   logic [6:0] m_th   [2];
   bit         m_vo   [2];
   int         m_ptr  [2];
   int         m_hold [2];

   function automatic int settle_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic logic [6:0] model_word(input int ptr, input int code, input bit dwa);
      logic [6:0] w;
      w = '0;
      for (int k = 0; k < code; k++) begin
         if (dwa) w[(ptr + k) % 7] = 1'b1;
         else     w[k] = 1'b1;
      end
      return w;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_th[i]   <= '0;
            m_vo[i]   <= 1'b0;
            m_ptr[i]  <= 0;
            m_hold[i] <= 0;
         end else if (v[i] && m_hold[i] == 0) begin
            m_th[i]   <= model_word(m_ptr[i], int'(c[i]), d[i]);
            m_ptr[i]  <= d[i] ? (m_ptr[i] + int'(c[i])) % 7 : m_ptr[i];
            m_vo[i]   <= 1'b1;
            m_hold[i] <= settle_of(i);
         end else begin
            m_vo[i] <= 1'b0;
            if (m_hold[i] > 0) m_hold[i] <= m_hold[i] - 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("model%0d therm", i), 32'(th[i]), 32'(m_th[i]));
            chk($sformatf("model%0d valid", i), 32'(vo[i]), 32'(m_vo[i]));
            chk($sformatf("model%0d ptr", i),   32'(p[i]),  32'(m_ptr[i]));
            chk($sformatf("model%0d ready", i), 32'(rdy[i]), 32'(m_hold[i] == 0));
         end
      end
   end

   task automatic wait_ready(input int i);
      int n;
      n = 0;
      while (rdy[i] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (rdy[i] !== 1'b1) begin
         nvec++;
         nerr++;
         $display("FAIL wait_ready dut%0d: ready_o=%b required 1 within 20 cycles", i, rdy[i]);
      end
   endtask

   // Returns at the negedge following the accepting edge.
   task automatic accept(input int i, input int code, input bit dwa);
      wait_ready(i);
      v[i] = 1'b1;
      c[i] = 3'(code);
      d[i] = dwa;
      @(negedge clk);
      v[i] = 1'b0;
   endtask

   initial begin
      int pulses;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         v[i] = 1'b0;
         c[i] = '0;
         d[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset therm", 32'(th[0]), 32'h00);
      chk("reset ptr",   32'(p[0]),  32'h0);
      chk("reset valid", 32'(vo[0]), 32'h0);
      chk("reset ready", 32'(rdy[0]), 32'h1);
      chk("reset ready s0", 32'(rdy[1]), 32'h1);

      // DWA off, settle timing
      accept(0, 5, 1'b0);
      chk("fixed5 therm", 32'(th[0]), 32'h1F);
      chk("fixed5 valid", 32'(vo[0]), 32'h1);
      chk("fixed5 ready N+1", 32'(rdy[0]), 32'h0);
      chk("fixed5 ptr", 32'(p[0]), 32'h0);
      @(negedge clk);
      chk("fixed5 ready N+2", 32'(rdy[0]), 32'h0);
      chk("fixed5 valid pulse", 32'(vo[0]), 32'h0);
      @(negedge clk);
      chk("fixed5 ready N+3", 32'(rdy[0]), 32'h1);
      chk("fixed5 therm holds", 32'(th[0]), 32'h1F);

      // DWA rotation with wrap
      accept(0, 3, 1'b1);
      chk("dwa3 therm", 32'(th[0]), 32'h07);
      chk("dwa3 ptr",   32'(p[0]),  32'h3);
      accept(0, 5, 1'b1);
      chk("dwa5 wrap therm", 32'(th[0]), 32'h79);
      chk("dwa5 wrap ptr",   32'(p[0]),  32'h1);
      accept(0, 7, 1'b1);
      chk("dwa7 therm", 32'(th[0]), 32'h7F);
      chk("dwa7 ptr",   32'(p[0]),  32'h1);
      accept(0, 0, 1'b1);
      chk("dwa0 therm", 32'(th[0]), 32'h00);
      chk("dwa0 ptr",   32'(p[0]),  32'h1);
      accept(0, 2, 1'b0);
      chk("fixed2 therm", 32'(th[0]), 32'h03);
      chk("fixed2 ptr kept", 32'(p[0]), 32'h1);

      // valid held through settle: accepts only every third edge
      wait_ready(0);
      v[0] = 1'b1;
      c[0] = 3'd1;
      d[0] = 1'b1;
      pulses = 0;
      repeat (9) begin
         @(negedge clk);
         if (vo[0] === 1'b1) pulses++;
      end
      v[0] = 1'b0;
      chk("held valid accepts", 32'(pulses), 32'd3);
      chk("held valid ptr", 32'(p[0]), 32'h4);

      // reset in the middle of a settle
      accept(0, 2, 1'b1);
      chk("dwa2 therm", 32'(th[0]), 32'h30);
      chk("dwa2 ready", 32'(rdy[0]), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid-settle reset ready", 32'(rdy[0]), 32'h1);
      chk("mid-settle reset therm", 32'(th[0]), 32'h00);
      chk("mid-settle reset ptr",   32'(p[0]),  32'h0);

      // no hold-off: back-to-back codes
      v[1] = 1'b1;
      d[1] = 1'b1;
      c[1] = 3'd1;
      @(negedge clk);
      chk("s0 code1 therm", 32'(th[1]), 32'h01);
      chk("s0 code1 ready", 32'(rdy[1]), 32'h1);
      c[1] = 3'd2;
      @(negedge clk);
      chk("s0 code2 therm", 32'(th[1]), 32'h06);
      chk("s0 code2 valid", 32'(vo[1]), 32'h1);
      c[1] = 3'd3;
      @(negedge clk);
      chk("s0 code3 therm", 32'(th[1]), 32'h38);
      chk("s0 code3 ptr",   32'(p[1]),  32'h6);
      @(negedge clk);
      chk("s0 wrap therm", 32'(th[1]), 32'h43);
      chk("s0 wrap ptr",   32'(p[1]),  32'h2);
      v[1] = 1'b0;
      @(negedge clk);
      chk("s0 idle valid", 32'(vo[1]), 32'h0);
      chk("s0 idle therm holds", 32'(th[1]), 32'h43);

      // extra mixed vectors, checked by the model alone
      accept(0, 6, 1'b1);
      accept(0, 4, 1'b1);
      accept(0, 1, 1'b0);
      accept(0, 7, 1'b1);
      accept(0, 3, 1'b1);
      accept(1, 5, 1'b1);
      accept(1, 6, 1'b0);
      accept(1, 4, 1'b1);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
